// File: rtl/btn_mode_ctrl.sv
// Push-button conditioner: two-flop sync, per-button debounce, press pulses and the movement-mode register.
// Define BTN_MODE_CYCLE_EN to make the centre button step through the modes instead of forcing CYLON.
//
//   state  | meaning
//   CYLON  | 2'b00, bounce back and forth
//   R_TO_L | 2'b01, sweep right to left
//   L_TO_R | 2'b10, sweep left to right
module btn_mode_ctrl #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd1_000_000,
    parameter logic [1:0]  MODE_RESET      = 2'b00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btnC,
    input  logic       btnL,
    input  logic       btnR,
    output logic [2:0] btn_db,
    output logic [2:0] press,
    output logic [1:0] mode,
    output logic       mode_changed
);

    localparam int CW = $clog2({8'd0, DEBOUNCE_CYCLES} + 32'd1);
    localparam logic [CW-1:0] CNT_TC = CW'({8'd0, DEBOUNCE_CYCLES} - 32'd1);

    typedef enum logic [1:0] {
        CYLON  = 2'b00,
        R_TO_L = 2'b01,
        L_TO_R = 2'b10
    } state_e;

    logic [2:0]    raw;
    logic [2:0]    s1_q, s2_q;
    logic [2:0]    db_q, db_d, db_dly_q;
    logic [2:0]    press_q;
    logic [CW-1:0] cnt_q [3];
    logic [CW-1:0] cnt_d [3];
    state_e        state_q, state_d;
    logic          mode_changed_q, mode_changed_d;

    // Channel order is {L,C,R} throughout.
    assign raw = {btnL, btnC, btnR};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            db_q           <= '0;
            db_dly_q       <= '0;
            press_q        <= '0;
            for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
            state_q        <= state_e'(MODE_RESET);
            mode_changed_q <= 1'b0;
        end else begin
            s1_q           <= raw;
            s2_q           <= s1_q;
            db_q           <= db_d;
            db_dly_q       <= db_q;
            press_q        <= db_q & ~db_dly_q;
            for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
            state_q        <= state_d;
            mode_changed_q <= mode_changed_d;
        end
    end

    // Any sample agreeing with the debounced level restarts the count.
    always_comb begin
        db_d = db_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != db_q[i]) begin
                if (cnt_q[i] == CNT_TC) db_d[i] = s2_q[i];
                else                    cnt_d[i] = cnt_q[i] + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        if (press_q[1]) begin
`ifdef BTN_MODE_CYCLE_EN
            case (state_q)
                CYLON:   state_d = R_TO_L;
                R_TO_L:  state_d = L_TO_R;
                default: state_d = CYLON;
            endcase
`else
            state_d = CYLON;
`endif
        end else if (press_q[0]) begin
            state_d = L_TO_R;
        end else if (press_q[2]) begin
            state_d = R_TO_L;
        end
        mode_changed_d = (state_d != state_q);
    end

    assign btn_db       = db_q;
    assign press        = press_q;
    assign mode         = state_q;
    assign mode_changed = mode_changed_q;

endmodule

// File: tb/tb_btn_mode_ctrl.sv
// Bench for btn_mode_ctrl with DEBOUNCE_CYCLES=4: sliding-window reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_btn_mode_ctrl;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btnC = 1'b0, btnL = 1'b0, btnR = 1'b0;
    logic [2:0] btn_db, press;
    logic [1:0] mode;
    logic       mode_changed;

    int n_tests = 0;
    int n_fail  = 0;
    int pcnt_l  = 0;
    int cyc     = 0;

    btn_mode_ctrl #(.DEBOUNCE_CYCLES(24'd4), .MODE_RESET(2'b00)) dut (
        .clk(clk), .rst(rst), .btnC(btnC), .btnL(btnL), .btnR(btnR),
        .btn_db(btn_db), .press(press), .mode(mode), .mode_changed(mode_changed)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference model: a debounced level flips once the last N synchronised samples
    // (raw samples taken 2..N+1 edges ago) all disagree with it.
    logic [N:0] m_h [3];
    logic [2:0] m_db, m_db_d, m_press;
    logic [1:0] m_mode;
    logic       m_chg;
    wire  [2:0] raw_v = {btnL, btnC, btnR};

    function automatic logic [1:0] nxt_mode(input logic [1:0] cur, input logic [2:0] p);
        if (p[1]) begin
`ifdef BTN_MODE_CYCLE_EN
            return 2'((int'(cur) + 1) % 3);
`else
            return 2'd0;
`endif
        end
        if (p[0]) return 2'd2;
        if (p[2]) return 2'd1;
        return cur;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) m_h[i] <= '0;
            m_db    <= '0;
            m_db_d  <= '0;
            m_press <= '0;
            m_mode  <= 2'd0;
            m_chg   <= 1'b0;
        end else begin
            for (int i = 0; i < 3; i++) begin
                m_h[i] <= {m_h[i][N-1:0], raw_v[i]};
                if (&(m_h[i][N:1] ^ {N{m_db[i]}})) m_db[i] <= ~m_db[i];
            end
            m_db_d  <= m_db;
            m_press <= m_db & ~m_db_d;
            m_mode  <= nxt_mode(m_mode, m_press);
            m_chg   <= (nxt_mode(m_mode, m_press) != m_mode);
        end
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        chk("model_btn_db", 32'(btn_db), 32'(m_db));
        chk("model_press", 32'(press), 32'(m_press));
        chk("model_mode", 32'(mode), 32'(m_mode));
        chk("model_mode_changed", 32'(mode_changed), 32'(m_chg));
        if (press[2]) pcnt_l <= pcnt_l + 1;
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic l, input logic c, input logic r);
        @(negedge clk);
        btnL = l; btnC = c; btnR = r;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        logic [1:0] exp_m;
        logic       exp_c;

        idle(2);
        #1;
        chk("reset_btn_db", 32'(btn_db), 32'd0);
        chk("reset_mode", 32'(mode), 32'd0);
        chk("reset_press", 32'(press), 32'd0);
        @(negedge clk) rst = 1'b0;

        // 1: clean R press, edge-accurate latency
        drive(0, 0, 1);
        wait_edges(5);  chk("t1_db_edge4", 32'(btn_db), 32'b000);
        wait_edges(1);  chk("t1_db_edge5", 32'(btn_db), 32'b001);
        wait_edges(1);  chk("t1_press_edge6", 32'(press), 32'b001);
        wait_edges(1);  chk("t1_mode_edge7", 32'(mode), 32'd2);
                        chk("t1_chg_edge7", 32'(mode_changed), 32'd1);
                        chk("t1_press_edge7", 32'(press), 32'b000);
        wait_edges(1);  chk("t1_chg_edge8", 32'(mode_changed), 32'd0);
        drive(0, 0, 0);
        idle(10);

        // 2: bouncing L, then held
        p0 = pcnt_l;
        drive(1, 0, 0); drive(0, 0, 0); drive(1, 0, 0); drive(0, 0, 0); drive(1, 0, 0);
        idle(14);
        chk("t2_press_l_count", 32'(pcnt_l - p0), 32'd1);
        chk("t2_mode", 32'(mode), 32'd1);
        drive(0, 0, 0);
        idle(10);

        // glitch of 3 cycles is filtered
        p0 = pcnt_l;
        drive(1, 0, 0);
        idle(3);
        btnL = 1'b0;
        idle(10);
        chk("glitch_press_l_count", 32'(pcnt_l - p0), 32'd0);
        chk("glitch_mode", 32'(mode), 32'd1);

        // 3: all three together from mode 10
        drive(0, 0, 1); idle(10); drive(0, 0, 0); idle(10);
        chk("t3_pre_mode", 32'(mode), 32'd2);
        drive(1, 1, 1);
        wait_edges(7);  chk("t3_press", 32'(press), 32'b111);
        wait_edges(1);  chk("t3_mode", 32'(mode), 32'd0);
                        chk("t3_chg", 32'(mode_changed), 32'd1);
        drive(0, 0, 0);
        idle(10);

        // 4: C again from mode 00
        drive(0, 1, 0);
        wait_edges(7);  chk("t4_press", 32'(press), 32'b010);
        wait_edges(1);
`ifdef BTN_MODE_CYCLE_EN
        exp_m = 2'd1; exp_c = 1'b1;
`else
        exp_m = 2'd0; exp_c = 1'b0;
`endif
        chk("t4_mode", 32'(mode), 32'(exp_m));
        chk("t4_chg", 32'(mode_changed), 32'(exp_c));
        drive(0, 0, 0);
        idle(10);

        // 5: reset mid-debounce on R
        drive(1, 0, 0); idle(10); drive(0, 0, 0); idle(10);
        chk("t5_pre_mode", 32'(mode), 32'd1);
        drive(0, 0, 1);
        wait_edges(4);
        rst = 1'b1;
        #1;
        chk("t5_rst_db", 32'(btn_db), 32'd0);
        chk("t5_rst_press", 32'(press), 32'd0);
        chk("t5_rst_mode", 32'(mode), 32'd0);
        chk("t5_rst_chg", 32'(mode_changed), 32'd0);
        @(negedge clk) rst = 1'b0;
        wait_edges(6);  chk("t5_press_edge5", 32'(press), 32'b000);
        wait_edges(1);  chk("t5_press_edge6", 32'(press), 32'b001);
        wait_edges(1);  chk("t5_mode_edge7", 32'(mode), 32'd2);
        drive(0, 0, 0);
        idle(10);

        // 6: three C presses from reset
        @(negedge clk) rst = 1'b1;
        @(negedge clk) rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(0, 1, 0);
            wait_edges(8);
`ifdef BTN_MODE_CYCLE_EN
            exp_m = 2'((k + 1) % 3); exp_c = 1'b1;
`else
            exp_m = 2'd0; exp_c = 1'b0;
`endif
            chk("t6_mode", 32'(mode), 32'(exp_m));
            chk("t6_chg", 32'(mode_changed), 32'(exp_c));
            drive(0, 0, 0);
            idle(10);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/btn_mode_ctrl.md
Name: btn_mode_ctrl

Overview:
- Front-end input conditioner for the LED sequencer top level.
- Takes the raw board push-buttons (btnC, btnL, btnR) and synchronises and debounces them.
- Produces single-cycle press pulses from the debounced buttons.
- Owns the registered 2-bit movement-mode value that feeds the LED sequencer's mode input. It replaces the ad-hoc raw-button mode register in the top level.

Parameters:
- DEBOUNCE_CYCLES, 24'd1_000_000, consecutive cycles a synchronised input must differ from the debounced level before that level flips (10 ms at 100 MHz). Legal range is 1 and up.
- MODE_RESET, 2'b00, value loaded into mode on reset.

Ports:
- clk, input, 1, system clock; all state updates on its rising edge.
- rst, input, 1, reset; asynchronous, active-high.
- btnC, input, 1, raw centre button; asynchronous to clk and bouncy.
- btnL, input, 1, raw left button.
- btnR, input, 1, raw right button.
- btn_db, output, 3, debounced levels {L,C,R}.
- press, output, 3, one-cycle rising-edge pulses {L,C,R}.
- mode, output, 2, current mode: 00 cylon, 01 right-to-left, 10 left-to-right. 11 is never produced.
- mode_changed, output, 1, one-cycle pulse whenever mode takes a new value.

Behaviour:
- Reset (asynchronous, while rst=1):
  - sync flops, btn_db, debounce counters, press and mode_changed all clear to 0.
  - mode loads MODE_RESET.
  - On release, operation resumes on the next clk edge.
  - A reset mid-debounce discards the partial count.
- Per-button pipeline (three identical channels):
  - Two-flop synchroniser s1 -> s2.
  - Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES+1).
  - Each edge with s2 != btn_db: if cnt == DEBOUNCE_CYCLES-1, then btn_db <= s2 and cnt <= 0; else cnt <= cnt+1.
  - Each edge with s2 == btn_db: cnt <= 0. A single bounce restarts the count.
  - press[i] <= btn_db[i] & ~btn_db_q[i], where btn_db_q is btn_db delayed one cycle. High for exactly one cycle per debounced rising edge. Release generates no pulse.
- Latency, with N = DEBOUNCE_CYCLES and edge 0 being the first edge sampling the raw input high:
  - s2 high after edge 1.
  - btn_db high after edge N+1.
  - press high after edge N+2, for one cycle.
  - mode updated after edge N+3.
  - mode_changed high after edge N+3, for one cycle.
- Mode state machine (states CYLON=00, R_TO_L=01, L_TO_R=10), evaluated on press:
  - press C -> CYLON.
  - press R -> L_TO_R.
  - press L -> R_TO_L.
  - Simultaneous pulses resolve by priority C > R > L.
  - No press -> hold.
- mode_changed is asserted only if the next mode differs from the current mode. Re-pressing the active mode gives no pulse.
- Button held through reset release: btn_db starts at 0, so after N+2 cycles a press is generated and acted on. This is intended.
- Button held indefinitely: exactly one press; the counter stays 0 while stable.
- Glitch shorter than N cycles after synchronisation: no change to btn_db, press or mode.

Optional Feature:
- Macro: BTN_MODE_CYCLE_EN.
- With the macro defined:
  - press C advances mode cyclically 00 -> 01 -> 10 -> 00.
  - mode_changed pulses on every C press.
  - L and R behave as without the macro.
  - C still has top priority when pulses coincide.
- Without the macro: press C forces CYLON (00), as described in Behaviour.

Test Plan (DEBOUNCE_CYCLES=4):
1. Reset, then hold btnR high clean -> btn_db[0] rises at edge 5; press[0] pulses at edge 6; mode = 10 and mode_changed=1 at edge 7; mode_changed is 0 at edge 8.
2. btnL bounces 1,0,1,0 at 1-cycle spacing, then holds high -> no press until 4 consecutive stable s2 samples; exactly one press[2]; mode = 01.
3. btnC, btnL and btnR rise on the same cycle from mode 10 -> press = 3'b111 for one cycle; mode = 00; mode_changed=1.
4. From mode 00, press btnC again -> press[1] pulses; mode stays 00; mode_changed stays 0.
5. Assert rst for 1 cycle while the btnR counter = 2 -> all outputs 0 and mode = 00 immediately. With btnR still held, press[0] follows 6 cycles after release (edge N+2); mode = 10.
6. With BTN_MODE_CYCLE_EN defined, press btnC three times from reset -> mode goes 01, 10, 00, with a mode_changed pulse on each press.
